// File: rtl/ram_hs_buf_pkg.sv
// Shared helpers for the handshake buffer RAM: width calculations for
// counters and pointers that follow the buffer depth.
package ram_hs_buf_pkg;

  // Bits needed to hold a count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a ring of depth entries; a single entry still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_hs_buf_if.sv
// Write / read-address / read-data handshake bundle for ram_hs_buf.
interface ram_hs_buf_if import ram_hs_buf_pkg::*; #(
  parameter int WIDTH  = 512,
  parameter int ADDR_W = 6,
  parameter int STRB_W = 4,
  parameter int CNT_W  = cnt_width(2)
);
  logic              wvalid;
  logic              wready;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [STRB_W-1:0] wstrb;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [WIDTH-1:0]  rdata;
  logic [CNT_W-1:0]  rd_pending;

  modport master (
    output wvalid, waddr, wdata, wstrb, arvalid, araddr, rready,
    input  wready, arready, rvalid, rdata, rd_pending
  );

  modport slave (
    input  wvalid, waddr, wdata, wstrb, arvalid, araddr, rready,
    output wready, arready, rvalid, rdata, rd_pending
  );
endinterface

// File: rtl/ram_hs_rbuf.sv
// Read-return FIFO. When empty, an incoming push is presented at the head in
// the same cycle so a read can be consumed straight out of the RAM register;
// it is only stored if it is not popped that cycle.
module ram_hs_rbuf import ram_hs_buf_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 512,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             store;
  logic             pop_mem;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Decide what enters/leaves storage and advance pointers and occupancy.
  always_comb begin
    empty    = (count_q == '0);
    store    = push && !(empty && pop);
    pop_mem  = pop && !empty;
    wr_ptr_d = store   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_mem ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (store && !pop_mem)      count_d = count_q + CNT_W'(1);
    else if (!store && pop_mem) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy state; cleared (discarding contents) on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; data needs no reset because occupancy gates it.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr_q] <= din;
  end

  assign head  = empty ? din : mem[rd_ptr_q];
  assign valid = push || !empty;
  assign count = count_q;

  no_overfill: assert property (@(posedge clk) disable iff (!rst_n)
    !(store && !pop_mem && count_q == CNT_W'(DEPTH)));
endmodule

// File: rtl/ram_hs_sram.sv
// Single-read-port / single-write-port RAM with registered read data.
// Contents are never reset; read data holds until the next read.
module ram_hs_sram #(
  parameter int SRAM_BIT     = 128,
  parameter int SRAM_BYTE    = 1,
  parameter int SRAM_WORD    = 64,
  parameter int CLOCK_PERIOD = 10,
  localparam int WIDTH       = SRAM_BIT * SRAM_BYTE,
  localparam int ADDR_W      = $clog2(SRAM_WORD)
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [SRAM_WORD];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read port, shaped for block-RAM inference.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

  period_positive: assert property (@(posedge clk) CLOCK_PERIOD > 0);
endmodule

// File: rtl/ram_hs_buf.sv
// Handshake wrapper around byte-lane RAMs: strobed writes, credit-limited
// reads that return in order through a small return buffer, and read blocking
// on a same-cycle write to the same address.
module ram_hs_buf import ram_hs_buf_pkg::*; #(
  parameter int SRAM_BIT       = 128,
  parameter int SRAM_BYTE      = 4,
  parameter int SRAM_WORD      = 64,
  parameter int CLOCK_PERIOD   = 10,
  parameter int RD_BUF_DEPTH   = 2,
  parameter int SRAM_WIDTH     = SRAM_BIT * SRAM_BYTE,
  parameter int SRAM_DEPTH_BIT = $clog2(SRAM_WORD)
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_hs_buf_if.slave  bus
);
  localparam int CNT_W = cnt_width(RD_BUF_DEPTH);

  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      buf_count;
  logic [CNT_W-1:0]      pending;
  logic                  collision;
  logic                  arready;
  logic                  ar_fire;
  logic                  buf_valid;
  logic                  pop;
  logic [SRAM_WIDTH-1:0] ram_rdata;
  logic [SRAM_WIDTH-1:0] buf_head;

  // Read admission: credits come from registered state only, and a read to
  // the address being written this cycle waits so it sees the new data.
  always_comb begin
    pending    = CNT_W'(inflight_q) + buf_count;
    collision  = bus.wvalid && (bus.waddr == bus.araddr);
    arready    = (pending < CNT_W'(RD_BUF_DEPTH)) && !collision;
    ar_fire    = bus.arvalid && arready;
    inflight_d = ar_fire;
    pop        = buf_valid && bus.rready;
  end

  // Marks a RAM read whose data lands in the RAM output register next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= inflight_d;
  end

  for (genvar gi = 0; gi < SRAM_BYTE; gi++) begin : g_lane
    ram_hs_sram #(
      .SRAM_BIT     (SRAM_BIT),
      .SRAM_BYTE    (1),
      .SRAM_WORD    (SRAM_WORD),
      .CLOCK_PERIOD (CLOCK_PERIOD)
    ) u_sram (
      .clk   (clk),
      .wen   (bus.wvalid && bus.wstrb[gi]),
      .waddr (bus.waddr),
      .wdata (bus.wdata[gi*SRAM_BIT +: SRAM_BIT]),
      .ren   (ar_fire),
      .raddr (bus.araddr),
      .rdata (ram_rdata[gi*SRAM_BIT +: SRAM_BIT])
    );
  end

  ram_hs_rbuf #(
    .DEPTH (RD_BUF_DEPTH),
    .WIDTH (SRAM_WIDTH),
    .CNT_W (CNT_W)
  ) u_rbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .din   (ram_rdata),
    .head  (buf_head),
    .valid (buf_valid),
    .count (buf_count)
  );

  assign bus.wready     = 1'b1;
  assign bus.arready    = arready;
  assign bus.rvalid     = buf_valid;
  assign bus.rdata      = buf_head;
  assign bus.rd_pending = pending;

  credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    pending <= CNT_W'(RD_BUF_DEPTH));
endmodule
